bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 18 +
 rtl/bit_serializer_if.sv | 25 ++
 rtl/bit_serializer.sv | 124 ++++++++++++
 tb/tb_bit_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared constants and types for the bit serializer: FSM encodings and counter sizing.
package bit_serializer_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SHIFT_ENC = 2'd1;
    localparam logic [1:0] GAP_ENC   = 2'd2;

    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MIN_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_SHIFT = SHIFT_ENC,
        ST_GAP   = GAP_ENC
    } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word input and serial-stream output bundle of the bit serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             lsb_first;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             word_done;

    // Upstream word producer
    modport master (
        output in_data, in_valid, lsb_first,
        input  in_ready, x, x_valid, busy, word_done
    );

    // The serializer itself
    modport slave (
        input  in_data, in_valid, lsb_first,
        output in_ready, x, x_valid, busy, word_done
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one bit per cycle, selectable bit order, optional idle gap per word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  bus
);

    localparam logic                 GAP_EN   = (GAP != 0);
    localparam logic [WIDTH-1:0]     LAST_IDX = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     CNT_ONE  = WIDTH'(1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [WIDTH-1:0]     r_cnt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic                 r_lsb;
    logic                 r_x;
    logic                 r_x_valid;
    logic                 r_busy;
    logic                 r_word_done;
    logic                 r_in_ready;

    logic                 w_accept;
    logic                 w_first_bit;
    logic [WIDTH-1:0]     w_load_shreg;
    logic                 w_next_bit;
    logic                 w_last;

    // Readiness is purely registered, so acceptance never loops back through in_valid
    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_first_bit  = bus.lsb_first ? bus.in_data[0] : bus.in_data[WIDTH-1];
    assign w_load_shreg = bus.lsb_first ? (bus.in_data >> 1) : (bus.in_data << 1);
    assign w_next_bit   = r_lsb ? r_shreg[0] : r_shreg[WIDTH-1];
    assign w_last       = (r_cnt == '0);

    // Shift register pre-shifted by one at load so the next bit is always at the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_lsb       <= 1'b0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_cnt       <= r_cnt - CNT_ONE;
                        r_shreg     <= r_lsb ? (r_shreg >> 1) : (r_shreg << 1);
                        r_x         <= w_next_bit;
                        r_word_done <= (r_cnt == CNT_ONE);
                        r_in_ready  <= !GAP_EN && (r_cnt == CNT_ONE);
                    end else if (GAP_EN) begin
                        r_state     <= ST_GAP;
                        r_gap_cnt   <= GAP_LOAD;
                        r_x         <= 1'b0;
                        r_x_valid   <= 1'b0;
                        r_word_done <= 1'b0;
                        r_in_ready  <= 1'b0;
                    end else begin
                        // A back-to-back accept below overrides this return to idle
                        r_state     <= ST_IDLE;
                        r_x         <= 1'b0;
                        r_x_valid   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_word_done <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_gap_cnt  <= r_gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_x         <= 1'b0;
                    r_x_valid   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_word_done <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase

            if (w_accept) begin
                r_state     <= ST_SHIFT;
                r_shreg     <= w_load_shreg;
                r_lsb       <= bus.lsb_first;
                r_cnt       <= LAST_IDX;
                r_x         <= w_first_bit;
                r_x_valid   <= 1'b1;
                r_busy      <= 1'b1;
                r_word_done <= 1'b0;
                r_in_ready  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.x         = r_x;
    assign bus.x_valid   = r_x_valid;
    assign bus.busy      = r_busy;
    assign bus.word_done = r_word_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three instances (GAP = 0, 2, 3) sharing clock and reset.
module tb_bit_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    sb_t q0[$];
    sb_t q1[$];
    sb_t q2[$];

    int run0      = 0;
    int max_run0  = 0;
    int wd_cyc0[$];
    int gap_run1  = 0;
    int gap_runs1[$];
    int done2     = 0;
    int acc2      = 0;

    bit_serializer_if #(.WIDTH(8)) if0 ();
    bit_serializer_if #(.WIDTH(8)) if1 ();
    bit_serializer_if #(.WIDTH(8)) if2 ();

    bit_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    bit_serializer #(.WIDTH(8), .GAP(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    bit_serializer #(.WIDTH(8), .GAP(3)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {in_ready, busy, x_valid, x, word_done}
    function automatic logic [4:0] outs(input int d);
        case (d)
            0:       return {if0.in_ready, if0.busy, if0.x_valid, if0.x, if0.word_done};
            1:       return {if1.in_ready, if1.busy, if1.x_valid, if1.x, if1.word_done};
            default: return {if2.in_ready, if2.busy, if2.x_valid, if2.x, if2.word_done};
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] w, input logic lsb);
        case (d)
            0:       begin if0.in_valid = v; if0.in_data = w; if0.lsb_first = lsb; end
            1:       begin if1.in_valid = v; if1.in_data = w; if1.lsb_first = lsb; end
            default: begin if2.in_valid = v; if2.in_data = w; if2.lsb_first = lsb; end
        endcase
    endtask

    // Reference bit order, independent of the DUT's shift mechanics
    task automatic push_word(input int d, input logic [7:0] w, input logic lsb);
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = lsb ? w[i] : w[7-i];
            e.last = (i == 7);
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send(input int d, input logic [7:0] w, input logic lsb);
        logic [4:0] o;
        drive(d, 1'b1, w, lsb);
        for (int t = 0; t < 100; t++) begin
            o = outs(d);
            if (o[4]) begin
                push_word(d, w, lsb);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        o = outs(d);
        check("send_timeout_ready", 32'(o[4]), 32'd1);
    endtask

    task automatic drain(input int d);
        logic [4:0] o;
        for (int t = 0; t < 300; t++) begin
            o = outs(d);
            if (qsize(d) == 0 && !o[3]) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("drain_queue_empty", 32'(qsize(d)), 32'd0);
    endtask

    task automatic mon_bit(input string tag, input logic [4:0] o, input int n, input sb_t e);
        if (o[2]) begin
            check({tag, "_expected_bit_present"}, 32'(n != 0), 32'd1);
            if (n != 0) begin
                check({tag, "_x"},         32'(o[1]), 32'(e.b));
                check({tag, "_word_done"}, 32'(o[0]), 32'(e.last));
            end
            check({tag, "_busy_in_shift"}, 32'(o[3]), 32'd1);
        end else begin
            check({tag, "_x_idle_zero"},  32'(o[1]), 32'd0);
            check({tag, "_done_idle"},    32'(o[0]), 32'd0);
        end
    endtask

    always @(negedge clk) begin : mon0
        sb_t e;
        int n;
        if (!reset) begin
            n = q0.size();
            e = '0;
            if (if0.x_valid && n != 0) e = q0.pop_front();
            mon_bit("d0", outs(0), n, e);
            if (if0.x_valid) begin
                run0++;
                if (run0 > max_run0) max_run0 = run0;
            end else begin
                run0 = 0;
            end
            if (if0.word_done) wd_cyc0.push_back(cyc);
        end
    end

    always @(negedge clk) begin : mon1
        sb_t e;
        int n;
        if (!reset) begin
            n = q1.size();
            e = '0;
            if (if1.x_valid && n != 0) e = q1.pop_front();
            mon_bit("d1", outs(1), n, e);
            if (if1.busy && !if1.x_valid) begin
                gap_run1++;
                check("d1_ready_low_in_gap", 32'(if1.in_ready), 32'd0);
            end else if (gap_run1 != 0) begin
                gap_runs1.push_back(gap_run1);
                gap_run1 = 0;
            end
        end
    end

    always @(negedge clk) begin : mon2
        sb_t e;
        int n;
        if (!reset) begin
            n = q2.size();
            e = '0;
            if (if2.x_valid && n != 0) e = q2.pop_front();
            mon_bit("d2", outs(2), n, e);
            if (if2.word_done) done2++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time %0t reached limit 400000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_state_d0", 32'(outs(0)), 32'b10000);
        check("rst_state_d1", 32'(outs(1)), 32'b10000);
        check("rst_state_d2", 32'(outs(2)), 32'b10000);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // MSB first, 8'hB0
        send(0, 8'hB0, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        drain(0);

        // LSB first, 8'h0D
        send(0, 8'h0D, 1'b1);
        drive(0, 1'b0, 8'h00, 1'b0);
        drain(0);

        // Back-to-back with in_valid held, no gap
        max_run0 = 0;
        wd_cyc0.delete();
        send(0, 8'hFF, 1'b0);
        send(0, 8'h00, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        drain(0);
        check("b2b_contiguous_valid", 32'(max_run0), 32'd16);
        check("b2b_done_count", 32'(wd_cyc0.size()), 32'd2);
        if (wd_cyc0.size() >= 2)
            check("b2b_done_spacing", 32'(wd_cyc0[1] - wd_cyc0[0]), 32'd8);

        // Two-cycle gap between words
        gap_runs1.delete();
        send(1, 8'h5A, 1'b0);
        send(1, 8'hC3, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0);
        drain(1);
        check("gap_run_count", 32'(gap_runs1.size()), 32'd2);
        foreach (gap_runs1[i]) check("gap_run_length", 32'(gap_runs1[i]), 32'd2);

        // Reset during bit 4 of 8'hA5, then a clean word
        send(0, 8'hA5, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_word_d0", 32'(outs(0)), 32'b10000);
        q0.delete();
        @(posedge clk);
        #1;
        check("rst_held_d0", 32'(outs(0)), 32'b10000);
        #1 reset = 1'b0;
        @(negedge clk);
        send(0, 8'h81, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        drain(0);

        // in_valid held 20 cycles with GAP = 3; inputs scrambled whenever not ready
        done2 = 0;
        acc2  = 0;
        for (int i = 0; i < 20; i++) begin
            if (if2.in_ready) begin
                drive(2, 1'b1, 8'h3C, 1'b0);
                push_word(2, 8'h3C, 1'b0);
                acc2++;
            end else begin
                drive(2, 1'b1, 8'($urandom), 1'($urandom));
            end
            @(negedge clk);
        end
        drive(2, 1'b0, 8'h00, 1'b0);
        drain(2);
        // Accept period is 8 bits + 3 gap + 1 idle = 12 cycles: accepts at 0 and 12
        check("hold_accept_count", 32'(acc2), 32'd2);
        check("hold_word_done_count", 32'(done2), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
